// File: rtl/fib_seq_ctrl_if.sv
// Bundle between host logic, the Fibonacci sequencer and the shared ALU.
// slave = sequencer side, master = host/ALU side. fsm_state mirrors the sequencer FSM for observation.
interface fib_seq_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 5
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] f0;
  logic [WIDTH-1:0] f1;
  logic [CNT_W-1:0] n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fn;
  logic             ovf;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic [1:0]       fsm_state;

  // Request/response contract: start is a level sampled on every posedge and only
  // acted on in IDLE (no queuing); done is a single-cycle pulse that qualifies fn/ovf.
  modport slave (
    input  start, abort, f0, f1, n, alu_y,
    output busy, done, fn, ovf, alu_op, alu_a, alu_b, fsm_state
  );

  modport master (
    output start, abort, f0, f1, n, alu_y,
    input  busy, done, fn, ovf, alu_op, alu_a, alu_b, fsm_state
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// N-term Fibonacci sequencer driving a shared combinational ALU (IDLE -> RUN -> DONE).
// Optional sticky overflow detection is built only when FIB_OVF_DET_EN is defined.
module fib_seq_ctrl #(
  parameter int         WIDTH  = 6,
  parameter int         CNT_W  = 5,
  parameter logic [2:0] ADD_OP = 3'b000
) (
  input  logic            clk,
  input  logic            rst,
  fib_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] fn_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             step;
  logic             finish;

  assign accept = (state == IDLE) && bus.start;
  // abort wins over both stepping and finishing
  assign step   = (state == RUN) && !bus.abort && (cnt > CNT_W'(1));
  assign finish = (state == RUN) && !bus.abort && (cnt <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.abort)               state_nxt = IDLE;
        else if (cnt <= CNT_W'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r0   <= '0;
      r1   <= '0;
      cnt  <= '0;
      fn_q <= '0;
    end else if (accept) begin
      r0  <= bus.f0;
      r1  <= bus.f1;
      cnt <= bus.n;
    end else if (step) begin
      r0  <= r1;
      r1  <= bus.alu_y;
      cnt <= cnt - CNT_W'(1);
    end else if (finish) begin
      fn_q <= (cnt == '0) ? r0 : r1;
    end
  end

`ifdef FIB_OVF_DET_EN
  // Private carry-out adder mirrors the ALU add so overflow needs no ALU flag.
  logic [WIDTH:0] sum_ext;
  logic           ovf_q;

  assign sum_ext = {1'b0, r0} + {1'b0, r1};

  always_ff @(posedge clk) begin
    if (!rst)                       ovf_q <= 1'b0;
    else if (accept)                ovf_q <= 1'b0;
    else if (step && sum_ext[WIDTH]) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.fn        = fn_q;
  assign bus.alu_op    = ADD_OP;
  assign bus.alu_a     = r0;
  assign bus.alu_b     = r1;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl: scoreboard of expected {done cycle, fn, ovf} popped on each done pulse.
// Expected ovf values follow FIB_OVF_DET_EN when the bench is compiled with it.
module tb_fib_seq_ctrl;
  localparam int WIDTH = 6;
  localparam int CNT_W = 5;
  localparam int EW    = 16 + WIDTH + 1;
`ifdef FIB_OVF_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  logic [EW-1:0] exp_q[$];

  fib_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ADD_OP(3'b000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU model: add for op 000, zero otherwise.
  assign bus.alu_y = (bus.alu_op == 3'b000) ? (bus.alu_a + bus.alu_b) : '0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (got running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present a start for one cycle at a negedge; optionally push the expected result
  task automatic start_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [CNT_W-1:0] nn, input bit push,
                           input logic [WIDTH-1:0] e_fn, input bit e_ovf, input bit ab);
    int lat;
    @(negedge clk);
    bus.f0    = a;
    bus.f1    = b;
    bus.n     = nn;
    bus.start = 1'b1;
    bus.abort = ab;
    lat = 2 + ((nn > 0) ? int'(nn) - 1 : 0);
    if (push) exp_q.push_back({16'(cyc + lat), e_fn, e_ovf & OVF_EN});
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    check({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("done_cycle", 32'(cyc[15:0]), 32'(e[EW-1 -: 16]));
        check("fn", 32'(bus.fn), 32'(e[WIDTH:1]));
        check("ovf", 32'(bus.ovf), 32'(e[0]));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.f0    = '0;
    bus.f1    = '0;
    bus.n     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_fn", 32'(bus.fn), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_alu_a", 32'(bus.alu_a), 0);
    check("rst_alu_b", 32'(bus.alu_b), 0);
    check("rst_alu_op", 32'(bus.alu_op), 0);
    rst = 1'b1;

    // basic run with busy window
    start_run(6'd1, 6'd1, 5'd5, 1, 6'd8, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check("run_busy", 32'(bus.busy), 1);
      @(negedge clk);
    end
    check("run_busy_after", 32'(bus.busy), 0);

    // n=0 / n=1 terminal cases, back-to-back
    start_run(6'd7, 6'd9, 5'd0, 1, 6'd7, 0, 0);
    wait_idle("n0");
    start_run(6'd7, 6'd9, 5'd1, 1, 6'd9, 0, 0);
    wait_idle("n1");

    // wraparound and overflow
    start_run(6'd1, 6'd1, 5'd10, 1, 6'd25, 1, 0);
    wait_idle("n10");
    start_run(6'd1, 6'd1, 5'd9, 1, 6'd55, 0, 0);
    wait_idle("n9");
    start_run(6'd1, 6'd1, 5'd31, 1, 6'd5, 1, 0);
    wait_idle("n31");
    // abort held alongside start must not block it
    start_run(6'd63, 6'd63, 5'd2, 1, 6'd62, 1, 1);
    wait_idle("wrap2");

    // abort mid-run: no done, fn held
    start_run(6'd1, 6'd1, 5'd20, 0, '0, 0, 0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_fn_kept", 32'(bus.fn), 62);
    start_run(6'd1, 6'd1, 5'd5, 1, 6'd8, 0, 0);
    wait_idle("after_abort");

    // start during run is ignored
    start_run(6'd1, 6'd1, 5'd5, 1, 6'd8, 0, 0);
    repeat (2) @(negedge clk);
    bus.f0 = 6'd3;
    bus.f1 = 6'd3;
    bus.n  = 5'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("ignored_start");

    // synchronous reset mid-run
    start_run(6'd1, 6'd1, 5'd20, 0, '0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_glitch_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #2;
    check("rst_between_edges_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_fn", 32'(bus.fn), 0);
    check("midrst_alu_a", 32'(bus.alu_a), 0);
    check("midrst_alu_b", 32'(bus.alu_b), 0);
    rst = 1'b1;
    start_run(6'd1, 6'd1, 5'd3, 1, 6'd3, 0, 0);
    wait_idle("post_reset");

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
